// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32 integer subset with memory-timeout traps.
// Optional performance counters are enabled by defining MCYC_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] instr_i,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ready_i,
    input  logic        branch_taken_i,
    output logic [2:0]  cmp_funct_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        alu_src_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic        reg_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        retire_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [2:0]  state_o
`ifdef MCYC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_ST   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_alu, is_mem, is_store, is_jump, legal, dec_active;
    logic       unused_instr_bits;

    assign opc      = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign is_alu   = (opc == OP_R) || (opc == OP_I);
    assign is_mem   = (opc == OP_LD) || (opc == OP_ST);
    assign is_store = (opc == OP_ST);
    assign is_jump  = (opc == OP_JAL) || (opc == OP_JALR);
    assign legal    = is_alu || is_mem || is_jump || (opc == OP_BR);
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    // IR contents are meaningless while fetching, so decode outputs are qualified by state.
    assign dec_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                        (state_q == S_MEM)    || (state_q == S_WB);

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        cause_d     = cause_q;
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        cmp_funct_o = 3'b000;
        alu_ctrl_o  = 4'b0000;
        alu_src_o   = 1'b0;
        pc_we_o     = 1'b0;
        pc_src_o    = 2'b00;
        reg_we_o    = 1'b0;
        wb_sel_o    = 2'b00;
        retire_o    = 1'b0;

        if (dec_active) begin
            alu_src_o = !((opc == OP_I) || is_mem || (opc == OP_JALR));
            if (opc == OP_BR) begin
                cmp_funct_o = funct3;
            end
            case (opc)
                OP_R: begin
                    if (funct7 == 7'd0) begin
                        case (funct3)
                            3'b000:  alu_ctrl_o = 4'b0010;
                            3'b111:  alu_ctrl_o = 4'b0000;
                            default: alu_ctrl_o = 4'b0001;
                        endcase
                    end else begin
                        alu_ctrl_o = 4'b0110;
                    end
                end
                OP_BR:                alu_ctrl_o = 4'b0110;
                OP_LD, OP_ST, OP_JALR: alu_ctrl_o = 4'b0010;
                OP_I:                 alu_ctrl_o = 4'b1111;
                default:              alu_ctrl_o = 4'b0000;
            endcase
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIM) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    state_d = S_WB;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else if (opc == OP_BR) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = branch_taken_i ? 2'b01 : 2'b00;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jump) begin
                    pc_we_o  = 1'b1;
                    pc_src_o = (opc == OP_JAL) ? 2'b10 : 2'b11;
                    state_d  = S_WB;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_ready_i) begin
                    if (is_store) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LIM) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we_o = 1'b1;
                retire_o = 1'b1;
                // Jumps already wrote their target PC in EXEC.
                pc_we_o  = !is_jump;
                if (opc == OP_LD) begin
                    wb_sel_o = 2'b01;
                end else if (is_jump) begin
                    wb_sel_o = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    assign trap_o       = (state_q == S_TRAP);
    assign trap_cause_o = cause_q;
    assign state_o      = state_q;

`ifdef MCYC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (retire_o) begin
                instret_cnt_d = instret_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction strobe tallies and latency, traps and mid-op reset.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] instr_i;
    logic        imem_req_o, imem_ready_i, ir_we_o;
    logic        dmem_req_o, dmem_we_o, dmem_ready_i;
    logic        branch_taken_i;
    logic [2:0]  cmp_funct_o;
    logic [3:0]  alu_ctrl_o;
    logic        alu_src_o, pc_we_o, reg_we_o, retire_o, trap_o;
    logic [1:0]  pc_src_o, wb_sel_o, trap_cause_o;
    logic [2:0]  state_o;
`ifdef MCYC_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_i(instr_i),
        .imem_req_o(imem_req_o), .imem_ready_i(imem_ready_i), .ir_we_o(ir_we_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i),
        .branch_taken_i(branch_taken_i), .cmp_funct_o(cmp_funct_o),
        .alu_ctrl_o(alu_ctrl_o), .alu_src_o(alu_src_o),
        .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
        .retire_o(retire_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o), .state_o(state_o)
`ifdef MCYC_PERF_CNT_EN
        , .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    int r_cycles, r_regwe, r_regwe_cyc, r_retire, r_pcwe, r_irwe, r_dreq, r_dwe;
    int fcnt, dcnt;
    logic [1:0] r_pcsrc, r_wbsel;
    logic [3:0] r_alu;
    logic       r_alusrc;
    logic [2:0] r_cmp;
    logic       done;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start state: FETCH at posedge+1. Runs until retire or trap, bounded.
    task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly, input logic tk);
        instr_i = ins; branch_taken_i = tk;
        fcnt = 0; dcnt = 0; done = 1'b0;
        r_cycles = 0; r_regwe = 0; r_regwe_cyc = 0; r_retire = 0; r_pcwe = 0; r_irwe = 0;
        r_dreq = 0; r_dwe = 0; r_pcsrc = 2'b00; r_wbsel = 2'b00; r_alu = 4'h0; r_alusrc = 1'b0; r_cmp = 3'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            imem_ready_i = imem_req_o && (fcnt == idly);
            if (imem_req_o) fcnt++;
            dmem_ready_i = dmem_req_o && (dcnt == ddly);
            if (dmem_req_o) dcnt++;
            #1;
            if (c == idly + 3) begin
                r_alu = alu_ctrl_o; r_alusrc = alu_src_o; r_cmp = cmp_funct_o;
            end
            if (ir_we_o) r_irwe++;
            if (reg_we_o) begin r_regwe++; r_regwe_cyc = c; r_wbsel = wb_sel_o; end
            if (pc_we_o) begin r_pcwe++; r_pcsrc = pc_src_o; end
            if (retire_o) r_retire++;
            if (dmem_req_o) begin r_dreq++; if (dmem_we_o) r_dwe++; end
            r_cycles = c + 1;
            if (retire_o || trap_o) done = 1'b1;
            tick();
        end
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        if (!done) chk_eq("run_bound", 0, 1);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0; branch_taken_i = 1'b0; instr_i = 32'h0;
        tick(); tick();
        rst_n_i = 1'b1;
        #1;
        chk_eq("idle_state", state_o, 3'd0);
        tick();
        chk_eq("fetch_state", state_o, 3'd1);
    endtask

    initial begin
        rst_n_i = 1'b0;
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0; branch_taken_i = 1'b0; instr_i = 32'h0;
        tick(); tick();
        chk_eq("rst_state", state_o, 3'd0);
        chk_eq("rst_imem_req", imem_req_o, 1'b0);
        chk_eq("rst_trap", {trap_o, trap_cause_o}, 3'b000);
        chk_eq("rst_strobes", {ir_we_o, pc_we_o, reg_we_o, retire_o, dmem_req_o}, 5'b0);
`ifdef MCYC_PERF_CNT_EN
        chk_eq("rst_cyc_cnt", cycle_cnt_o, 0);
`endif
        rst_n_i = 1'b1;
        #1;
        chk_eq("idle_state", state_o, 3'd0);
        chk_eq("idle_imem_req", imem_req_o, 1'b0);
        tick();
        chk_eq("fetch_state", state_o, 3'd1);
        chk_eq("fetch_imem_req", imem_req_o, 1'b1);

        // add x1,x2,x3
        run_instr(32'h003100B3, 0, 0, 1'b0);
        chk_eq("add_cycles", r_cycles, 5);
        chk_eq("add_alu", r_alu, 4'b0010);
        chk_eq("add_alusrc", r_alusrc, 1'b1);
        chk_eq("add_regwe", r_regwe, 1);
        chk_eq("add_regwe_cyc", r_regwe_cyc, 4);
        chk_eq("add_retire", r_retire, 1);
        chk_eq("add_irwe", r_irwe, 1);
        chk_eq("add_pc", {r_pcwe[1:0], r_pcsrc}, {2'd1, 2'b00});
        chk_eq("add_wbsel", r_wbsel, 2'b00);
`ifdef MCYC_PERF_CNT_EN
        chk_eq("add_instret", instret_cnt_o, 1);
`endif

        // lw x1,0(x2) with dmem ready after 3 wait cycles
        run_instr(32'h00012083, 0, 3, 1'b0);
        chk_eq("lw_cycles", r_cycles, 9);
        chk_eq("lw_dreq", r_dreq, 4);
        chk_eq("lw_dwe", r_dwe, 0);
        chk_eq("lw_wbsel", r_wbsel, 2'b01);
        chk_eq("lw_regwe", r_regwe, 1);
        chk_eq("lw_alu", {r_alu, r_alusrc}, {4'b0010, 1'b0});

        // sw x1,0(x2)
        run_instr(32'h00112023, 0, 0, 1'b0);
        chk_eq("sw_cycles", r_cycles, 5);
        chk_eq("sw_dwe", r_dwe, 1);
        chk_eq("sw_regwe", r_regwe, 0);
        chk_eq("sw_pc", {r_pcwe[1:0], r_pcsrc, r_retire[1:0]}, {2'd1, 2'b00, 2'd1});

        // beq taken, then not taken; bne exposes funct3
        run_instr(32'h00208463, 0, 0, 1'b1);
        chk_eq("beq_t_cycles", r_cycles, 4);
        chk_eq("beq_t_pcsrc", r_pcsrc, 2'b01);
        chk_eq("beq_t_regwe", r_regwe, 0);
        chk_eq("beq_alu", {r_alu, r_cmp}, {4'b0110, 3'b000});
        run_instr(32'h00208463, 0, 0, 1'b0);
        chk_eq("beq_n_cycles", r_cycles, 4);
        chk_eq("beq_n_pc", {r_pcwe[1:0], r_pcsrc, r_retire[1:0]}, {2'd1, 2'b00, 2'd1});
        run_instr(32'h00209463, 0, 0, 1'b0);
        chk_eq("bne_cmp", r_cmp, 3'b001);

        // jal / jalr
        run_instr(32'h008000EF, 0, 0, 1'b0);
        chk_eq("jal_cycles", r_cycles, 5);
        chk_eq("jal_pc", {r_pcwe[1:0], r_pcsrc}, {2'd1, 2'b10});
        chk_eq("jal_wb", {r_regwe[1:0], r_wbsel}, {2'd1, 2'b10});
        run_instr(32'h000080E7, 0, 0, 1'b0);
        chk_eq("jalr_pc", {r_pcwe[1:0], r_pcsrc}, {2'd1, 2'b11});
        chk_eq("jalr_alu", {r_alu, r_alusrc}, {4'b0010, 1'b0});

        // ALU code table
        run_instr(32'h00108093, 0, 0, 1'b0);
        chk_eq("addi_alu", {r_alu, r_alusrc}, {4'b1111, 1'b0});
        chk_eq("addi_cycles", r_cycles, 5);
        run_instr(32'h403100B3, 0, 0, 1'b0);
        chk_eq("sub_alu", r_alu, 4'b0110);
        run_instr(32'h003170B3, 0, 0, 1'b0);
        chk_eq("and_alu", r_alu, 4'b0000);
        run_instr(32'h003160B3, 0, 0, 1'b0);
        chk_eq("or_alu", r_alu, 4'b0001);

        // imem ready on the 16th request cycle: no trap
        run_instr(32'h003100B3, 15, 0, 1'b0);
        chk_eq("f16_trap", trap_o, 1'b0);
        chk_eq("f16_cycles", r_cycles, 20);
        chk_eq("f16_retire", r_retire, 1);

        // illegal opcode
        run_instr(32'h0000007F, 0, 0, 1'b0);
        chk_eq("ill_trap", {trap_o, trap_cause_o}, {1'b1, 2'b01});
        chk_eq("ill_state", state_o, 3'd6);
        begin
            int reqs = 0;
            int strb = 0;
            for (int i = 0; i < 6; i++) begin
                imem_ready_i = 1'b1;
                #1;
                if (imem_req_o) reqs++;
                if (ir_we_o || pc_we_o || reg_we_o || retire_o || dmem_req_o) strb++;
                tick();
            end
            imem_ready_i = 1'b0;
            chk_eq("ill_no_req", reqs, 0);
            chk_eq("ill_no_strobe", strb, 0);
            chk_eq("ill_sticky", {trap_o, trap_cause_o}, {1'b1, 2'b01});
        end

        // imem never ready
        do_reset();
        run_instr(32'h003100B3, 100, 0, 1'b0);
        chk_eq("imem_to_cause", {trap_o, trap_cause_o}, {1'b1, 2'b10});
        chk_eq("imem_to_reqs", fcnt, 16);

        // dmem never ready
        do_reset();
        run_instr(32'h00012083, 0, 100, 1'b0);
        chk_eq("dmem_to_cause", {trap_o, trap_cause_o}, {1'b1, 2'b11});
        chk_eq("dmem_to_reqs", r_dreq, 16);

        // reset asserted while in MEM
        do_reset();
        instr_i = 32'h00012083;
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        tick(); tick();
        chk_eq("mid_mem_req", {dmem_req_o, state_o}, {1'b1, 3'd4});
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_eq("mid_rst_req", dmem_req_o, 1'b0);
        chk_eq("mid_rst_state", state_o, 3'd0);
`ifdef MCYC_PERF_CNT_EN
        chk_eq("mid_rst_cnt", {cycle_cnt_o, instret_cnt_o}, 64'd0);
`endif
        tick();
        rst_n_i = 1'b1;
        tick();
        chk_eq("restart_fetch", {state_o, imem_req_o}, {3'd1, 1'b1});
        run_instr(32'h003100B3, 0, 0, 1'b0);
        chk_eq("restart_retire", r_retire, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
